// File: rtl/mtm_alu_deserializer_pkg.sv
// Shared types for the MTM ALU serial receiver: opcodes, frame types, error flags, CRC4.
// The CRC helper is only referenced when MTM_DESER_CRC_CHECK_EN is defined.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;

    localparam int DATA_FRAMES_DEF = 8;

    typedef struct packed {
        logic data;
        logic crc;
        logic op;
    } err_flags_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Serial CRC4, polynomial x^4+x+1, init 0, message consumed MSB first.
    function automatic logic [3:0] crc4_68(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// Decoded-request handshake between the serial receiver (master) and the ALU core (slave).
interface mtm_alu_deserializer_if;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        err_data;
    logic        err_crc;
    logic        err_op;
    logic        overrun;

    modport master (
        output out_valid, a, b, op, err_data, err_crc, err_op, overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid, a, b, op, err_data, err_crc, err_op, overrun,
        output out_ready
    );

endinterface

// File: rtl/mtm_alu_deserializer_frame_rx.sv
// 11-bit frame receiver: start, type, 8 data bits MSB first, stop.
//  state | meaning
//  IDLE  | line idle, waiting for a 0 start bit
//  TYPE  | sampling the type bit (0 data, 1 cmd)
//  DATA  | shifting in d[7]..d[0]
//  STOP  | sampling stop bit; 1 emits the frame, 0 flags a framing error
//  FLUSH | after a bad stop bit, wait for the line to return high
module mtm_frame_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic       frame_valid,
    output logic       frame_type,
    output logic [7:0] frame_byte,
    output logic       frame_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TYPE  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       type_q, type_d;
    logic [7:0] byte_q, byte_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        type_d    = type_q;
        byte_d    = byte_q;
        case (state_q)
            S_IDLE: begin
                if (!sin) state_d = S_TYPE;
            end
            S_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                byte_d    = {byte_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: begin
                state_d = sin ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                if (sin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            type_q    <= FRAME_DATA;
            byte_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            type_q    <= type_d;
            byte_q    <= byte_d;
        end
    end

    // Frame results are combinational in STOP so the packet stage can register them on the stop-bit edge.
    assign frame_valid = (state_q == S_STOP) && sin;
    assign frame_err   = (state_q == S_STOP) && !sin;
    assign frame_type  = type_q;
    assign frame_byte  = byte_q;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// MTM ALU serial receiver: packet assembly, length/CRC/opcode checks and output register.
// Define MTM_DESER_CRC_CHECK_EN to build the CRC checker; otherwise err_crc is tied low.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_FRAMES = DATA_FRAMES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sin,
    mtm_alu_deserializer_if.master out_if
);

    localparam int               CNT_W    = $clog2(DATA_FRAMES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

    logic       frame_valid;
    logic       frame_type;
    logic [7:0] frame_byte;
    logic       frame_err;

    mtm_frame_rx u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .frame_valid (frame_valid),
        .frame_type  (frame_type),
        .frame_byte  (frame_byte),
        .frame_err   (frame_err)
    );

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ferr_q, ferr_d;
    logic [63:0]      sh_q, sh_d;

    always_comb begin
        cnt_d  = cnt_q;
        ferr_d = ferr_q;
        sh_d   = sh_q;
        if (frame_err) ferr_d = 1'b1;
        if (frame_valid) begin
            if (frame_type == FRAME_DATA) begin
                sh_d = {sh_q[55:0], frame_byte};
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d  = '0;
                ferr_d = 1'b0;
            end
        end
    end

    // Decode of the packet closed by the current cmd frame: B in the upper word, A below.
    logic [31:0] a_rx, b_rx;
    logic [2:0]  op_rx;
    err_flags_t  err_rx;
    logic        any_err;

    assign b_rx  = sh_q[63:32];
    assign a_rx  = sh_q[31:0];
    assign op_rx = frame_byte[6:4];

`ifdef MTM_DESER_CRC_CHECK_EN
    logic [3:0] crc_calc;
    assign crc_calc = crc4_68({b_rx, a_rx, 1'b1, op_rx});
`endif

    always_comb begin
        err_rx.data = (cnt_q != CNT_FULL) || ferr_q;
`ifdef MTM_DESER_CRC_CHECK_EN
        err_rx.crc  = !err_rx.data && (frame_byte[3:0] != crc_calc);
`else
        err_rx.crc  = 1'b0;
`endif
        err_rx.op   = !err_rx.data && !err_rx.crc && !op_legal(op_rx);
    end

    assign any_err = err_rx.data | err_rx.crc | err_rx.op;

    logic        pkt_done, load;
    logic        valid_q, ovr_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    err_flags_t  err_q;

    assign pkt_done = frame_valid && (frame_type == FRAME_CMD);
    assign load     = pkt_done && (!valid_q || out_if.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            err_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ferr_q <= ferr_d;
            sh_q   <= sh_d;
            if (load) begin
                valid_q <= 1'b1;
                a_q     <= any_err ? 32'h0 : a_rx;
                b_q     <= any_err ? 32'h0 : b_rx;
                op_q    <= any_err ? 3'b000 : op_rx;
                err_q   <= err_rx;
            end else if (valid_q && out_if.out_ready) begin
                valid_q <= 1'b0;
            end
            // Packet completed while the previous result is still held: dropped.
            if (pkt_done && !load) ovr_q <= 1'b1;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.a         = a_q;
    assign out_if.b         = b_q;
    assign out_if.op        = op_q;
    assign out_if.err_data  = err_q.data;
    assign out_if.err_crc   = err_q.crc;
    assign out_if.err_op    = err_q.op;
    assign out_if.overrun   = ovr_q;

endmodule

// File: doc/mtm_alu_deserializer.md
# mtm_alu_deserializer

Serial input receiver for the MTM ALU. Consumes the bit stream on `sin` (data bytes plus one command byte per packet), frames it into 11-bit frames and assembles operands A and B and the opcode. It checks packet length, CRC and opcode, then presents one decoded request or error per packet to the ALU core through a valid/ready handshake. It is the first stage inside the DUT, directly downstream of the stimulus that drives `sin`.

## Interface
Parameters:
- `DATA_FRAMES`, 8: data frames per packet (4 for B, then 4 for A).

Ports:
- `clk`  in  1  system clock; `sin` carries one bit per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sin`  in  1  serial input; idle high.
- `out_ready`  in  1  core accepts the current output.
- `out_valid`  out  1  a decoded packet or error is held on the outputs.
- `a`  out  32  operand A.
- `b`  out  32  operand B.
- `op`  out  3  opcode (`operation_t`).
- `err_data`  out  1  length or framing error.
- `err_crc`  out  1  CRC mismatch.
- `err_op`  out  1  illegal opcode.
- `overrun`  out  1  sticky; a packet was dropped because the output was still held.

## Operation
- Frame format, in order:
  - start bit 0;
  - type bit (0 = data, 1 = cmd);
  - `d[7]`..`d[0]`, MSB first;
  - stop bit 1.
- Frame FSM states and transitions:
  - IDLE: on `sin`=0 → TYPE.
  - TYPE: next cycle → DATA.
  - DATA: 8 cycles → STOP.
  - STOP: sample stop bit → IDLE.
  - If the stop bit is 0 → FLUSH. FLUSH waits for `sin`=1, then → IDLE.
- Packet assembly:
  - Data bytes shift in MSB first. The first 4 bytes form `b[31:0]`, the next 4 form `a[31:0]`.
  - Data-frame counter saturates at `DATA_FRAMES`+1.
  - Cmd byte is {0, op[2:0], crc[3:0]}.
- Error check on cmd frame, priority err_data > err_crc > err_op (exactly one flag set):
  - err_data: data count ≠ `DATA_FRAMES`, or any framing error since the last cmd.
  - err_crc: received crc ≠ CRC4 of the 68-bit word {B, A, 1'b1, op}. Polynomial x^4+x+1, init 0, MSB first.
  - err_op: op not in {AND=000, OR=001, ADD=100, SUB=101}.
- On an error result, `a`, `b`, `op` are driven 0.
- After a cmd frame the packet state clears (counter 0, framing-error flag 0), whatever the outcome.
- Output register: loaded when a packet completes and `out_valid`=0, or in the same cycle as an `out_ready` handshake.
  - Otherwise the completed packet is discarded and `overrun` is set.
  - `overrun` clears only on reset.

## Timing
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset takes effect mid-frame immediately; a partial packet is lost.
- Latency: `out_valid` rises in the cycle after the cmd frame's stop bit is sampled.
- Handshake:
  - `out_valid` with `a`, `b`, `op` and error flags stays stable until the cycle with `out_valid`&&`out_ready`.
  - `out_valid` drops the next cycle unless a new packet completes in that same cycle.
- Back-to-back: a start bit in the cycle right after a stop bit is accepted (zero idle gap).
- `sin` is never stalled; the receiver never backpressures.

## Configuration
- `MTM_DESER_CRC_CHECK_EN` defined: CRC is computed and checked as above.
- Undefined: no CRC logic; `err_crc` is tied to 0 and the received crc field is ignored.

## Structure
- `mtm_alu_pkg` holds:
  - `operation_t` (AND, OR, ADD, SUB);
  - the frame type constants (DATA=0, CMD=1);
  - the `DATA_FRAMES` default;
  - a packed error-flags struct {data, crc, op}.
- Sub-module `mtm_frame_rx`: owns the frame FSM. Emits `frame_valid` (1-cycle pulse), `frame_type`, `frame_byte[7:0]` and `frame_err`.
- The top level does packet assembly, CRC, checks and the output register.

## Test plan
- A=0x00000003, B=0x00000005, op=ADD, correct crc → `out_valid`, a=0x3, b=0x5, op=100, all errors 0, exactly 1 cycle after the cmd stop bit.
- Same packet, crc bit 0 inverted → `err_crc`=1, a=b=op=0. Undefining `MTM_DESER_CRC_CHECK_EN` → clean result instead.
- 7 data frames then cmd → `err_data`=1. 9 data frames then cmd → `err_data`=1. The next correct packet decodes cleanly.
- op=010 with correct crc → `err_op`=1. Stop bit forced to 0 in data frame 3 → `err_data`=1 on the following cmd.
- `rst_n` pulsed low after 4 data frames, then a full valid AND packet (A=0xFFFF0000, B=0x0F0F0F0F) → a single clean output, no errors.
- `out_ready` held 0, two valid packets sent back-to-back → the first packet is held unchanged and `overrun`=1. After `out_ready`, `out_valid` drops and `overrun` stays 1.
